// File: rtl/branch_flag_unit.sv
// Execute-stage flag register plus conditional-branch resolver.
// Taken branches raise a counted flush to squash younger instructions.
module branch_flag_unit #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [5:0]        alu_op,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_v,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [2:0]        br_cond,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] br_offset,
   output logic              br_done,
   output logic              br_taken,
   output logic [ADDR_W-1:0] br_target,
   output logic              flush,
   output logic [2:0]        flags_q
);

   typedef enum logic {IDLE, FLUSH} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [2:0]          flags_d;
   logic                done_q, done_d;
   logic                taken_q, taken_d;
   logic [ADDR_W-1:0]   tgt_q, tgt_d;
   logic                upd_full, upd_nz, capture, accept, cond_res;

   assign flush    = (state_q == FLUSH);
   assign br_ready = (state_q == IDLE);
   assign br_done  = done_q;
   assign br_taken = taken_q;
   assign br_target = tgt_q;

   assign upd_full = alu_op inside {6'h00, 6'h01, 6'h02};
   assign upd_nz   = alu_op inside {6'h03, 6'h04, 6'h22, 6'h23};
   assign capture  = alu_valid && !flush;
   assign accept   = br_valid && br_ready;

   // flags_d doubles as the forwarded flag value for a same-cycle branch
   always_comb begin
      flags_d = flags_q;
      if (capture && (upd_full || upd_nz))
         flags_d = {alu_n, alu_z, upd_full ? alu_v : 1'b0};
   end

   always_comb begin
      cond_res = 1'b0;
      case (br_cond)
         3'd0: cond_res = !flags_d[1];
         3'd1: cond_res = flags_d[1];
         3'd2: cond_res = !flags_d[1] && !flags_d[2];
         3'd3: cond_res = flags_d[2];
         3'd4: cond_res = !flags_d[2];
         3'd5: cond_res = flags_d[2] || flags_d[1];
         3'd6: cond_res = flags_d[0];
         default: cond_res = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      taken_d = taken_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               done_d  = 1'b1;
               taken_d = cond_res;
               tgt_d   = br_pc + br_offset;
               if (cond_res) begin
                  state_d = FLUSH;
                  cnt_d   = 4'(FLUSH_CYCLES - 1);
               end
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         taken_q <= 1'b0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         done_q  <= done_d;
         taken_q <= taken_d;
         tgt_q   <= tgt_d;
      end
   end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Bench for branch_flag_unit: two instances (2- and 4-cycle flush) share stimulus
// and are compared each cycle against a cycle-level behavioural model.
module tb_branch_flag_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic [5:0]  alu_op = '0;
   logic        alu_n = 1'b0, alu_z = 1'b0, alu_v = 1'b0;
   logic        br_valid = 1'b0;
   logic [2:0]  br_cond = '0;
   logic [31:0] br_pc = '0, br_offset = '0;

   logic [1:0]        ready, done, taken, flsh;
   logic [1:0][31:0]  tgt;
   logic [1:0][2:0]   flg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_flag_unit #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_op(alu_op),
      .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .br_valid(br_valid),
      .br_ready(ready[0]), .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset),
      .br_done(done[0]), .br_taken(taken[0]), .br_target(tgt[0]),
      .flush(flsh[0]), .flags_q(flg[0]));

   branch_flag_unit #(.ADDR_W(32), .FLUSH_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_op(alu_op),
      .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .br_valid(br_valid),
      .br_ready(ready[1]), .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset),
      .br_done(done[1]), .br_taken(taken[1]), .br_target(tgt[1]),
      .flush(flsh[1]), .flags_q(flg[1]));

   typedef struct {
      logic [2:0]  f;
      int          left;   // flush cycles still to be shown
      logic        done;
      logic        taken;
      logic [31:0] tgt;
   } mdl_t;

   mdl_t m[2];
   int   fc[2] = '{2, 4};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t got %0h exp %0h", tag, $time, got, exp);
      end
   endtask

   function automatic mdl_t mreset();
      mdl_t s;
      s.f = 3'b000; s.left = 0; s.done = 1'b0; s.taken = 1'b0; s.tgt = 32'h0;
      return s;
   endfunction

   function automatic bit eval_cond(input logic [2:0] c, input logic [2:0] f);
      bit n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic mdl_t mstep(input mdl_t s, input int fcyc);
      mdl_t r = s;
      bit busy = (s.left > 0);
      logic [2:0] eff = s.f;
      bit t;
      if (alu_valid && !busy) begin
         if (alu_op == 6'h00 || alu_op == 6'h01 || alu_op == 6'h02)
            eff = {alu_n, alu_z, alu_v};
         else if (alu_op == 6'h03 || alu_op == 6'h04 || alu_op == 6'h22 || alu_op == 6'h23)
            eff = {alu_n, alu_z, 1'b0};
      end
      r.f = eff;
      r.done = 1'b0;
      if (busy) r.left = s.left - 1;
      else if (br_valid) begin
         t = eval_cond(br_cond, eff);
         r.done = 1'b1;
         r.taken = t;
         r.tgt = br_pc + br_offset;
         if (t) r.left = fcyc;
      end
      return r;
   endfunction

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("flags%0d", i), 64'(flg[i]), 64'(m[i].f));
         chk($sformatf("done%0d", i), 64'(done[i]), 64'(m[i].done));
         chk($sformatf("taken%0d", i), 64'(taken[i]), 64'(m[i].taken));
         chk($sformatf("target%0d", i), 64'(tgt[i]), 64'(m[i].tgt));
         chk($sformatf("flush%0d", i), 64'(flsh[i]), 64'(m[i].left > 0));
         chk($sformatf("ready%0d", i), 64'(ready[i]), 64'(m[i].left == 0));
      end
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) m[i] = mstep(m[i], fc[i]);
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic av, input logic [5:0] op, input logic n, input logic z,
                        input logic v, input logic bv, input logic [2:0] c,
                        input logic [31:0] pc, input logic [31:0] off);
      alu_valid = av; alu_op = op; alu_n = n; alu_z = z; alu_v = v;
      br_valid = bv; br_cond = c; br_pc = pc; br_offset = off;
   endtask

   task automatic idle(input int n);
      drive(0, 6'h3F, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
      repeat (n) tick();
   endtask

   logic [5:0] ops[10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h22, 6'h23, 6'h05, 6'h06, 6'h3F};

   initial begin
      m[0] = mreset(); m[1] = mreset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // flag classes
      drive(1, 6'h00, 0, 1, 0, 0, 3'd0, 0, 0); tick(); chk("add_flags", 64'(flg[0]), 64'h2);
      drive(1, 6'h05, 1, 0, 0, 0, 3'd0, 0, 0); tick(); chk("sll_hold", 64'(flg[0]), 64'h2);
      drive(0, 6'h00, 1, 0, 1, 0, 3'd0, 0, 0); tick(); chk("novalid_hold", 64'(flg[0]), 64'h2);
      drive(1, 6'h23, 1, 0, 1, 0, 3'd0, 0, 0); tick(); chk("xor_vclr", 64'(flg[0]), 64'h4);
      drive(1, 6'h02, 0, 0, 1, 0, 3'd0, 0, 0); tick(); chk("sub_flags", 64'(flg[0]), 64'h1);

      // forwarding into a same-cycle EQ branch
      drive(1, 6'h00, 0, 0, 0, 0, 3'd0, 0, 0); tick();
      drive(1, 6'h02, 0, 1, 0, 1, 3'd1, 32'h100, 32'h20); tick();
      chk("fwd_taken", 64'(taken[0]), 64'h1);
      chk("fwd_target", 64'(tgt[0]), 64'h120);
      chk("fwd_flush", 64'(flsh[0]), 64'h1);
      idle(1); chk("fwd_flush2", 64'(flsh[0]), 64'h1);
      idle(1); chk("fwd_flush_end", 64'(flsh[0]), 64'h0);
      idle(3);

      // not taken with address wrap, then back-to-back UNCOND
      drive(1, 6'h00, 0, 0, 0, 0, 3'd0, 0, 0); tick();
      drive(0, 6'h3F, 0, 0, 0, 1, 3'd1, 32'hFFFF_FFF0, 32'h20); tick();
      chk("wrap_target", 64'(tgt[0]), 64'h10);
      chk("nt_taken", 64'(taken[0]), 64'h0);
      chk("nt_flush", 64'(flsh[0]), 64'h0);
      drive(0, 6'h3F, 0, 0, 0, 1, 3'd7, 32'h40, 32'hFFFF_FFFC); tick();
      chk("b2b_done", 64'(done[0]), 64'h1);
      chk("b2b_taken", 64'(taken[0]), 64'h1);

      // wrong-path ALU op and branch during flush
      drive(1, 6'h00, 0, 1, 0, 1, 3'd7, 32'h200, 32'h4); tick();
      chk("flush_flags", 64'(flg[0]), 64'h0);
      chk("flush_nodone", 64'(done[0]), 64'h0);
      idle(4);
      drive(0, 6'h3F, 0, 0, 0, 1, 3'd5, 32'h300, 32'h8); tick();
      chk("le_oldflags", 64'(taken[0]), 64'h0);

      // reset in the second cycle of a 4-cycle flush
      drive(1, 6'h01, 1, 1, 1, 1, 3'd7, 32'h500, 32'h10); tick();
      idle(1);
      chk("pre_rst_flush4", 64'(flsh[1]), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      m[0] = mreset(); m[1] = mreset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 6'h3F, 0, 0, 0, 1, 3'd7, 32'h600, 32'h4); tick();
      chk("post_rst_done", 64'(done[1]), 64'h1);
      chk("post_rst_target", 64'(tgt[1]), 64'h604);
      idle(4);

      // random traffic
      for (int k = 0; k < 600; k++) begin
         drive($urandom_range(0, 1),
               ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)],
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) != 0), 3'($urandom),
               ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : 32'($urandom),
               32'($urandom));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
